// File: rtl/jtag_seq_pkg.sv
// Shared types for the JTAG sequencing master: command opcodes, FSM states
// and the Test-Logic-Reset TMS run length.
package jtag_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SHIFT_IR = 2'd1,
    OP_SHIFT_DR = 2'd2,
    OP_NOP      = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TRST,
    ST_TLR,
    ST_SEL,
    ST_CAPT,
    ST_SHIFT,
    ST_EXIT,
    ST_UPD,
    ST_DONE
  } state_e;

  localparam int TLR_TMS_BITS = 5;

endpackage

// File: rtl/jtag_seq_tck_gen.sv
// TCK divider: CLK_DIV cycles low then CLK_DIV cycles high while run is set,
// with single-cycle strobes on the system cycle that ends each phase.
module jtag_seq_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] cnt;
  logic          last;

  assign last     = (cnt == DW'(CLK_DIV - 1));
  assign rise_stb = run && last && !tck;
  assign fall_stb = run && last && tck;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_seq_master.sv
// JTAG master sequencing RESET / SHIFT_IR / SHIFT_DR commands onto TCK/TMS/TDI.
// Define JTAG_SEQ_TRST_EN to precede RESET with a TRST pulse of TRST_CYC TCKs.
module jtag_seq_master
  import jtag_seq_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int IR_W     = 4,
  parameter int DATA_W   = 32,
  parameter int TRST_CYC = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [1:0]                i_cmd_op,
  input  logic [$clog2(DATA_W)-1:0] i_cmd_len,
  input  logic [DATA_W-1:0]         i_cmd_data,
  output logic                      o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_synced,
  output logic                      o_tck,
  output logic                      o_tms,
  output logic                      o_tdi,
  input  logic                      i_tdo,
  output logic                      o_trst
);

  localparam int LW = $clog2(DATA_W);
  localparam int CW = LW + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  op_e               op_q;
  logic [DATA_W-1:0] data_q, cap_q;
  logic [CW-1:0]     last_q;  // index of the final shift bit (N-1)
  logic              accept, run, fall_stb, rise_stb;
  logic              tms_q, tms_d, tdi_q, tdi_d;

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign run         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_tms       = tms_q;
  assign o_tdi       = tdi_q;

  jtag_seq_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (i_clk),
    .rst      (i_rst),
    .run      (run),
    .tck      (o_tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          case (op_e'(i_cmd_op))
`ifdef JTAG_SEQ_TRST_EN
            OP_RESET:    state_d = ST_TRST;
`else
            OP_RESET:    state_d = ST_TLR;
`endif
            OP_SHIFT_IR,
            OP_SHIFT_DR: state_d = ST_SEL;
            default:     state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        // Bits only advance at the end of a TCK high phase.
        if (fall_stb) begin
          cnt_d = cnt_q + 1'b1;
          case (state_q)
`ifdef JTAG_SEQ_TRST_EN
            ST_TRST:  if (cnt_q == CW'(TRST_CYC - 1)) begin state_d = ST_TLR; cnt_d = '0; end
`endif
            ST_TLR:   if (cnt_q == CW'(TLR_TMS_BITS)) begin state_d = ST_DONE; cnt_d = '0; end
            ST_SEL:   if (cnt_q == ((op_q == OP_SHIFT_IR) ? CW'(1) : CW'(0))) begin
                        state_d = ST_CAPT;
                        cnt_d   = '0;
                      end
            ST_CAPT:  if (cnt_q == CW'(1)) begin state_d = ST_SHIFT; cnt_d = '0; end
            ST_SHIFT: if (cnt_q == last_q) begin state_d = ST_EXIT; cnt_d = '0; end
            ST_EXIT:  begin state_d = ST_UPD;  cnt_d = '0; end
            ST_UPD:   begin state_d = ST_DONE; cnt_d = '0; end
            default:  begin state_d = ST_IDLE; cnt_d = '0; end
          endcase
        end
      end
    endcase

    // Pad values for the bit about to start; registered so they move with TCK falling.
    tms_d = 1'b1;
    tdi_d = 1'b0;
    case (state_d)
      ST_TLR:   tms_d = (cnt_d < CW'(TLR_TMS_BITS));
      ST_CAPT:  tms_d = 1'b0;
      ST_SHIFT: begin
        tms_d = (cnt_d == last_q);
        tdi_d = data_q[cnt_d[LW-1:0]];
      end
      ST_UPD:   tms_d = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end

`ifdef JTAG_SEQ_TRST_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_trst <= 1'b0;
    else       o_trst <= (state_d == ST_TRST);
  end
`else
  assign o_trst = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q        <= OP_NOP;
      data_q      <= '0;
      cap_q       <= '0;
      last_q      <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_synced    <= 1'b0;
    end else begin
      o_rsp_valid <= (state_q == ST_DONE);
      if (accept) begin
        op_q   <= op_e'(i_cmd_op);
        data_q <= i_cmd_data;
        cap_q  <= '0;
        last_q <= (op_e'(i_cmd_op) == OP_SHIFT_IR) ? CW'(IR_W - 1) : {1'b0, i_cmd_len};
      end
      if (rise_stb && (state_q == ST_SHIFT))
        cap_q <= {i_tdo, cap_q[DATA_W-1:1]};
      if (state_q == ST_DONE) begin
        // Captured bits sit at the MSB end; right-align them to the shift length.
        if ((op_q == OP_SHIFT_IR) || (op_q == OP_SHIFT_DR))
          o_rsp_data <= cap_q >> (CW'(DATA_W - 1) - last_q);
        else
          o_rsp_data <= '0;
        if (op_q == OP_RESET)
          o_synced <= 1'b1;
      end
    end
  end

endmodule
